// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multicycle RV32I core
module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [3:0] state_o,
    output logic       trap,
    output logic [1:0] trap_cause
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] trap_cause_q, trap_cause_d;

    logic mem_req_c, mem_write_c, ir_write_c, reg_write_c;
    logic pc_update, branch, timeout, mem_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_q       <= 8'd0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        wait_d       = 8'd0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src      = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        // mem_ready wins over an expiring wait budget
        timeout      = (LIMIT != 8'd0) && (wait_q == LIMIT) && !mem_ready;
        mem_state    = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);

        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_update  = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = (state_q == S_MEMWRITE) && !timeout;
                adr_src     = 1'b1;
                if (mem_ready) begin
                    state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        if (mem_state && !mem_ready && (state_d == state_q))
            wait_d = wait_q + 8'd1;
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // strobes are gated by rst_n so an asserted reset silences them immediately
    assign mem_req    = mem_req_c & rst_n;
    assign mem_write  = mem_write_c & rst_n;
    assign ir_write   = ir_write_c & rst_n;
    assign reg_write  = reg_write_c & rst_n;
    assign pc_write   = (pc_update | (branch & zero)) & rst_n;
    assign state_o    = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared memory port, ALU, register file and instruction register across the fetch, decode, execute, memory and writeback cycles.
- Drives every datapath select and write-enable, and handles the memory ready handshake.
- Detects illegal opcodes and memory timeouts and halts the core in a trap state.

Parameters:
WAIT_LIMIT, 255, max consecutive cycles a memory state may wait on mem_ready before trapping; 0 disables the timeout; range 0..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  opcode field of the instruction register (instr[6:0]); stable from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
mem_req  output  1  memory access request
mem_write  output  1  store strobe, valid with mem_req
adr_src  output  1  memory address select: 0 = PC, 1 = result
ir_write  output  1  load instruction register and old-PC register
pc_write  output  1  PC enable = pc_update OR (branch AND zero)
result_src  output  2  result select: 00 = ALU-out register, 01 = read data, 10 = ALU result
alu_src_a  output  2  ALU operand A select: 00 = PC, 01 = old PC, 10 = rs1 data
alu_src_b  output  2  ALU operand B select: 00 = rs2 data, 01 = immediate, 10 = constant 4
alu_op  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded
imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
reg_write  output  1  register file write enable
state_o  output  4  current state code (debug)
trap  output  1  core halted
trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = bus timeout

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=15.
- Reset (rst_n=0, asynchronous):
  - state = FETCH, wait counter = 0, trap = 0, trap_cause = 00.
  - While rst_n is low, mem_req, mem_write, ir_write, pc_write and reg_write are forced to 0.
  - A reset mid-operation aborts the instruction with no further strobes.
- Outputs are decoded combinationally from the state (plus mem_ready, zero and op where listed). Any output not listed for a state is 0.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, addi/I-ALU 0010011, beq 1100011, jal 1101111.
- imm_src is combinational from op: lw/I-ALU = 00, sw = 01, beq = 10, jal = 11, all others = 00.
- State outputs and transitions:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. If mem_ready: ir_write=1, pc_update=1, go to DECODE; else stay.
  - DECODE: a=01, b=01, alu_op=00 (branch/jump target into the ALU-out register). Next state by op: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, jal -> JAL, beq -> BEQ, any other -> TRAP with trap_cause=01.
  - MEMADR: a=10, b=01, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. On mem_ready go to MEMWB; else stay.
  - MEMWB: result_src=01, reg_write=1, go to FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. On mem_ready go to FETCH; else stay.
  - EXECR: a=10, b=00, alu_op=10, go to ALUWB.
  - EXECI: a=10, b=01, alu_op=10, go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, go to FETCH.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1, go to ALUWB.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, go to FETCH.
  - TRAP: all strobes 0, mem_req=0, trap=1, trap_cause held. Exit only by reset.
- Latency in cycles, with zero memory wait:
  - lw = 5
  - sw = 4
  - R-type / I-ALU = 4
  - jal = 4
  - beq = 3
  - Each memory wait cycle adds 1.
- Wait counter (8-bit):
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Cleared on any state change and whenever mem_ready=1.
  - If WAIT_LIMIT != 0 and the counter equals WAIT_LIMIT while mem_ready=0, go to TRAP with trap_cause=10. No write strobe is issued that cycle.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- mem_ready together with the timeout condition in the same cycle: mem_ready wins and the access completes.

Test Plan:
- lw, mem_ready held 1 -> state_o 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. ir_write=1 and pc_write=1 only in state 0.
- beq with zero=1, then a second beq with zero=0 -> pc_write=1 in the state-10 cycle of the first and 0 in the second. Both return to FETCH after 3 cycles. imm_src=10.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_req=1 and mem_write=1 for 4 cycles, no reg_write, then FETCH. Total 7 cycles.
- WAIT_LIMIT=4, mem_ready stuck at 0 in FETCH -> TRAP entered on the 5th FETCH cycle, trap=1, trap_cause=10, state_o=15. Stays there until rst_n pulses low.
- op=1111111 at DECODE -> TRAP, trap_cause=01, no strobes. jal -> states 0,1,9,7,0, with pc_write in state 9 and reg_write in state 7.
- rst_n driven low mid-MEMWRITE, asynchronous to clk -> mem_write drops immediately. After release, state_o=0, trap=0, and the next fetch proceeds normally.
